hello_seq_ctrl: RTL and testbench
=================================

HELLO_SEQ_CTRL -- requirements
Module: hello_seq_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50_000_000, meaning CLOCK_50 cycles per display step (1 s at 50 MHz); legal range 2..2^26.
REQ-002 The block SHALL have port CLOCK_50  input  1  the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port RUN  input  1  level; 1 = run sequence, 0 = pause (or idle when done).
REQ-005 The block SHALL have port MODE  input  1  0 = loop, 1 = one-shot; latched on IDLE->RUN.
REQ-006 The block SHALL have port STEP  input  1  synchronous; a 0->1 edge advances one step while paused.
REQ-007 The block SHALL have port SEL  output  3  select code driving the 5:1 mux; range 0..4 only.
REQ-008 The block SHALL have port HEX0  output  8  active-low 7-segment code for the current SEL.
REQ-009 The block SHALL have port BUSY  output  1  high in RUN and HOLD.
REQ-010 The block SHALL have port DONE  output  1  high in DONE state.

Function
REQ-011 The block SHALL implement states IDLE, RUN, HOLD and DONE.
REQ-012 The block SHALL have a prescaler cnt, width clog2(TICK_DIV), that increments only in RUN; tick = (cnt == TICK_DIV-1), after which cnt wraps to 0.
REQ-013 The block SHALL transition IDLE->RUN in the cycle after RUN is first sampled high, with cnt cleared, SEL = 0 and MODE latched.
REQ-014 The block SHALL, in RUN on a tick, advance SEL 0->1->2->3->4; at SEL=4 it SHALL wrap to 0 if latched MODE=0, or go to DONE with SEL held at 4 if latched MODE=1.
REQ-015 The block SHALL go RUN->HOLD when RUN is sampled low, freezing cnt and SEL.
REQ-016 The block SHALL go HOLD->RUN when RUN is sampled high, resuming from the frozen cnt.
REQ-017 The block SHALL, in HOLD on a registered STEP rising edge, advance SEL one step next cycle under the same wrap/one-shot rule, leaving cnt unchanged; a one-shot step from 4 SHALL enter DONE.
REQ-018 The block SHALL ignore STEP in IDLE, RUN and DONE; holding STEP high SHALL produce exactly one step.
REQ-019 The block SHALL go DONE->IDLE when RUN is sampled low; in DONE with RUN high it SHALL hold SEL = 4.
REQ-020 The block SHALL give priority to a tick when tick and a RUN fall coincide: the step is applied and the next state is HOLD (or DONE if one-shot ends).
REQ-021 The block SHALL drive HEX0 combinationally from state and SEL: IDLE = 8'hFF; otherwise SEL 0 = 8'h89 (H), 1 = 8'h86 (E), 2 = 8'hC7 (L), 3 = 8'hC7 (L), 4 = 8'hC0 (O); any other code = 8'hFF.
REQ-022 The block SHALL register SEL, BUSY and DONE, with no combinational path from inputs to outputs except through state.

Reset
REQ-023 The block SHALL, while RESET_N = 0 and independent of the clock, force state IDLE, SEL = 0, cnt = 0, latched MODE = 0, STEP edge register = 0, BUSY = 0, DONE = 0 and HEX0 = 8'hFF.
REQ-024 The block SHALL abandon any in-flight sequence on reset mid-operation, with no step completing.
REQ-025 The block SHALL, after release, sample RUN first on the next rising edge.

Structure
REQ-026 The block SHALL place the state encoding, segment constants (SEG_H, SEG_E, SEG_L, SEG_O, SEG_OFF) and SEL_LAST = 4 in a shared package hello_pkg.
REQ-027 The block SHALL implement the segment decode as the sub-module hello_seg_dec (3-bit in, 8-bit out, purely combinational), instantiated once.

Verification (TICK_DIV = 4)
REQ-028 Scenario 1 SHALL check: reset, then RUN = 1 with MODE = 0 -> SEL steps 0,1,2,3,4,0 every 4 cycles and HEX0 reads 89,86,C7,C7,C0,89.
REQ-029 Scenario 2 SHALL check: MODE = 1 with RUN held -> after 5 ticks DONE = 1, BUSY = 0, SEL = 4, HEX0 = C0 stable; RUN = 0 -> IDLE and HEX0 = FF.
REQ-030 Scenario 3 SHALL check: RUN dropped at cnt = 2, SEL = 1, then two STEP pulses (one held 3 cycles) -> SEL = 3 with cnt still 2; RUN = 1 -> the next tick comes after 2 cycles.
REQ-031 Scenario 4 SHALL check: RUN falls in the same cycle as a tick at SEL = 2 -> SEL = 3 and the state is HOLD.
REQ-032 Scenario 5 SHALL check: RESET_N asserted mid-step at SEL = 3 -> outputs immediately SEL = 0, HEX0 = FF, BUSY = 0, with no further step after release until RUN is seen.
REQ-033 Scenario 6 SHALL check: STEP in IDLE, RUN and DONE -> no change to SEL.

Source files
------------

// File: rtl/hello_pkg.sv
// Shared definitions for the HELLO sequencer: state encoding, segment codes
// and the select-advance helper used by the controller.
package hello_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Active-low 7-segment codes for the letters of "HELLO"
  localparam logic [7:0] SEG_H   = 8'h89;
  localparam logic [7:0] SEG_E   = 8'h86;
  localparam logic [7:0] SEG_L   = 8'hC7;
  localparam logic [7:0] SEG_O   = 8'hC0;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [2:0] SEL_LAST = 3'd4;

  function automatic logic [2:0] sel_adv(input logic [2:0] sel);
    return (sel >= SEL_LAST) ? 3'd0 : sel + 3'd1;
  endfunction

endpackage

// File: rtl/hello_seg_dec.sv
// Purely combinational decode of the 3-bit letter select to an active-low
// 7-segment pattern; unused codes blank the display.
module hello_seg_dec
  import hello_pkg::*;
(
  input  logic [2:0] sel,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (sel)
      3'd0:    seg = SEG_H;
      3'd1:    seg = SEG_E;
      3'd2:    seg = SEG_L;
      3'd3:    seg = SEG_L;
      3'd4:    seg = SEG_O;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/hello_seq_ctrl.sv
// Steps a 5:1 letter select through H-E-L-L-O at a prescaled rate, with
// pause/single-step and loop or one-shot operation.
module hello_seq_ctrl
  import hello_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       RUN,
  input  logic       MODE,
  input  logic       STEP,
  output logic [2:0] SEL,
  output logic [7:0] HEX0,
  output logic       BUSY,
  output logic       DONE
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    sel_n;
  logic          mode_q, mode_n;
  logic          step_q;
  logic          step_rise;
  logic          last_step;
  logic [7:0]    seg_raw;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      SEL    <= '0;
      mode_q <= 1'b0;
      step_q <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      SEL    <= sel_n;
      mode_q <= mode_n;
      step_q <= STEP;
      BUSY   <= (state_n == ST_RUN) || (state_n == ST_HOLD);
      DONE   <= (state_n == ST_DONE);
    end
  end

  // A one-shot run ends when a step is due while showing the final letter
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sel_n     = SEL;
    mode_n    = mode_q;
    step_rise = STEP && !step_q;
    last_step = (SEL == SEL_LAST) && mode_q;
    case (state)
      ST_IDLE: begin
        if (RUN) begin
          state_n = ST_RUN;
          cnt_n   = '0;
          sel_n   = '0;
          mode_n  = MODE;
        end
      end
      ST_RUN: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (last_step) begin
            state_n = ST_DONE;
          end else begin
            sel_n = sel_adv(SEL);
            if (!RUN) state_n = ST_HOLD;
          end
        end else if (RUN) begin
          cnt_n = cnt + CW'(1);
        end else begin
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (RUN) begin
          state_n = ST_RUN;
        end else if (step_rise) begin
          if (last_step) state_n = ST_DONE;
          else           sel_n   = sel_adv(SEL);
        end
      end
      ST_DONE: begin
        if (!RUN) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  hello_seg_dec u_seg_dec (
    .sel (SEL),
    .seg (seg_raw)
  );

  assign HEX0 = (state == ST_IDLE) ? SEG_OFF : seg_raw;

endmodule

// File: tb/tb_hello_seq_ctrl.sv
// Self-checking bench for hello_seq_ctrl: directed vector table, hand-written
// multi-cycle corner cases and a randomized run against a behavioural model.
module tb_hello_seq_ctrl;

  localparam int TD = 4;

  logic       CLOCK_50;
  logic       RESET_N;
  logic       RUN;
  logic       MODE;
  logic       STEP;
  logic [2:0] SEL;
  logic [7:0] HEX0;
  logic       BUSY;
  logic       DONE;

  int total = 0;
  int bad   = 0;

  // Reference model: "active" covers running or paused, "paused" is the hold
  int  mSel;
  int  mCnt;
  bit  mActive;
  bit  mPaused;
  bit  mDone;
  bit  mOneShot;
  bit  mPrevStep;
  logic [7:0] segTab [5];

  typedef struct {
    bit         run;
    bit         mode;
    bit         step;
    int         ncyc;
    logic [2:0] sel;
    logic [7:0] hex;
    bit         busy;
    bit         done;
  } vec_t;

  vec_t vecs [6];

  hello_seq_ctrl #(.TICK_DIV(TD)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .RUN      (RUN),
    .MODE     (MODE),
    .STEP     (STEP),
    .SEL      (SEL),
    .HEX0     (HEX0),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [2:0] eSel,
                             input logic [7:0] eHex, input bit eBusy, input bit eDone);
    total++;
    if (SEL !== eSel || HEX0 !== eHex || BUSY !== eBusy || DONE !== eDone) begin
      bad++;
      $display("[TB] FAIL %s: got sel=%0d hex=%h busy=%0b done=%0b, want sel=%0d hex=%h busy=%0b done=%0b",
               name, SEL, HEX0, BUSY, DONE, eSel, eHex, eBusy, eDone);
    end
  endtask

  task automatic modelReset();
    mSel = 0; mCnt = 0; mActive = 0; mPaused = 0;
    mDone = 0; mOneShot = 0; mPrevStep = 0;
  endtask

  task automatic modelAdvance();
    if (mOneShot && mSel == 4) begin
      mActive = 0;
      mPaused = 0;
      mDone   = 1;
    end else begin
      mSel = (mSel + 1) % 5;
    end
  endtask

  task automatic modelStep(input bit run, input bit mode, input bit step);
    bit rise;
    rise = step && !mPrevStep;
    mPrevStep = step;
    if (mDone) begin
      if (!run) mDone = 0;
    end else if (!mActive) begin
      if (run) begin
        mActive = 1; mPaused = 0; mCnt = 0; mSel = 0; mOneShot = mode;
      end
    end else if (!mPaused) begin
      if (mCnt == TD - 1) begin
        mCnt = 0;
        modelAdvance();
        if (mActive && !run) mPaused = 1;
      end else if (run) begin
        mCnt++;
      end else begin
        mPaused = 1;
      end
    end else begin
      if (run)       mPaused = 0;
      else if (rise) modelAdvance();
    end
  endtask

  // One clock with the given inputs, then compare against the model
  task automatic applyStimulus(input bit run, input bit mode, input bit step);
    logic [7:0] eHex;
    RUN = run; MODE = mode; STEP = step;
    @(posedge CLOCK_50);
    modelStep(run, mode, step);
    @(negedge CLOCK_50);
    eHex = (!mActive && !mDone) ? 8'hFF : segTab[mSel];
    checkOutput("model", 3'(mSel), eHex, mActive, mDone);
  endtask

  task automatic doReset();
    RESET_N = 1'b0; RUN = 1'b0; MODE = 1'b0; STEP = 1'b0;
    modelReset();
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    checkOutput("reset", 3'd0, 8'hFF, 1'b0, 1'b0);
    RESET_N = 1'b1;
  endtask

  initial begin
    segTab[0] = 8'h89; segTab[1] = 8'h86; segTab[2] = 8'hC7;
    segTab[3] = 8'hC7; segTab[4] = 8'hC0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1, 3'd0, 8'h89, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 4, 3'd1, 8'h86, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 4, 3'd2, 8'hC7, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 4, 3'd3, 8'hC7, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 4, 3'd4, 8'hC0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 4, 3'd0, 8'h89, 1'b1, 1'b0};

    RESET_N = 1'b0; RUN = 1'b0; MODE = 1'b0; STEP = 1'b0;
    modelReset();

    // Loop mode walks H E L L O H, one letter per TD cycles
    $display("[TB] loop sequence");
    doReset();
    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].ncyc; c++)
        applyStimulus(vecs[i].run, vecs[i].mode, vecs[i].step);
      checkOutput($sformatf("vec%0d", i), vecs[i].sel, vecs[i].hex, vecs[i].busy, vecs[i].done);
    end

    // One-shot ends in DONE on O; STEP there is ignored; RUN low returns to idle
    $display("[TB] one-shot");
    doReset();
    for (int c = 0; c < 21; c++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("oneshot_done", 3'd4, 8'hC0, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) applyStimulus(1'b1, 1'b1, c[0]);
    checkOutput("done_step_ignored", 3'd4, 8'hC0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("done_to_idle", 3'd4, 8'hFF, 1'b0, 1'b0);

    // Pause at cnt=2 on E, two STEP pulses (second held), then resume
    $display("[TB] hold and step");
    doReset();
    for (int c = 0; c < 7; c++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("hold_entry", 3'd1, 8'h86, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("two_steps", 3'd3, 8'hC7, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resume_no_tick_yet", 3'd3, 8'hC7, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resume_tick", 3'd4, 8'hC0, 1'b1, 1'b0);

    // RUN falls on the same cycle as a tick at L
    $display("[TB] tick with run fall");
    doReset();
    for (int c = 0; c < 12; c++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pre_tick", 3'd2, 8'hC7, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("tick_wins", 3'd3, 8'hC7, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("held_after_tick", 3'd3, 8'hC7, 1'b1, 1'b0);

    // Asynchronous reset in the middle of the second L
    $display("[TB] async reset mid-run");
    doReset();
    for (int c = 0; c < 15; c++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pre_reset", 3'd3, 8'hC7, 1'b1, 1'b0);
    #2;
    RESET_N = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_immediate", 3'd0, 8'hFF, 1'b0, 1'b0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle_after_reset", 3'd0, 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restart", 3'd0, 8'h89, 1'b1, 1'b0);

    // STEP toggling in IDLE and RUN has no effect on SEL
    $display("[TB] step ignored");
    doReset();
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, c[0]);
    checkOutput("idle_step", 3'd0, 8'hFF, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) applyStimulus(1'b1, 1'b0, ~c[0]);
    checkOutput("run_step", 3'd0, 8'h89, 1'b1, 1'b0);

    // Randomized run against the model
    $display("[TB] random");
    doReset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) doReset();
      applyStimulus($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
